// File: rtl/slot_allocator_pkg.sv
// Shared types and helpers for the slot allocator: slot count, index and mask types,
// and a free-slot population count used for reset/flush values.
package slot_allocator_pkg;

    localparam int unsigned NumSlots = 8;
    localparam int unsigned IdxW     = 3;

    typedef logic [IdxW-1:0]     slot_idx_t;
    typedef logic [NumSlots-1:0] slot_mask_t;
    typedef logic [IdxW:0]       slot_cnt_t;

    function automatic slot_cnt_t popcount_free(input slot_mask_t mask);
        slot_cnt_t n;
        n = '0;
        for (int i = 0; i < NumSlots; i++) begin
            if (!mask[i]) n = n + slot_cnt_t'(1);
        end
        return n;
    endfunction

endpackage

// File: rtl/slot_allocator_if.sv
// Allocation/free/flush handshake and status bundle between a requester and the allocator.
interface slot_allocator_if;
    import slot_allocator_pkg::*;

    logic       alloc_req;
    logic       alloc_gnt;
    slot_idx_t  alloc_idx;
    logic       free_valid;
    slot_idx_t  free_idx;
    logic       flush;
    slot_mask_t busy_mask;
    slot_cnt_t  free_count;
    logic       full;
    logic       err_double_free;

    modport master (
        output alloc_req, free_valid, free_idx, flush,
        input  alloc_gnt, alloc_idx, busy_mask, free_count, full, err_double_free
    );

    modport slave (
        input  alloc_req, free_valid, free_idx, flush,
        output alloc_gnt, alloc_idx, busy_mask, free_count, full, err_double_free
    );

endinterface

// File: rtl/slot_allocator_ctz.sv
// CountTrailingZero utility: index of the lowest set bit of val, or 8 when val is zero.
module CountTrailingZero (
    input  logic [7:0] val,
    output logic [3:0] count
);

    always_comb begin
        count = 4'd8;
        // Scan downwards so the lowest set bit is the last one written.
        for (int i = 7; i >= 0; i--) begin
            if (val[i]) count = 4'(i);
        end
    end

endmodule

// File: rtl/slot_allocator.sv
// 8-slot allocator granting the lowest free slot with same-cycle grant.
// Optional macro SLOT_ALLOC_BYPASS_EN lets a full allocator hand a freed slot straight over.
module slot_allocator
    import slot_allocator_pkg::*;
#(
    parameter slot_mask_t RESET_BUSY = 8'h00
) (
    input  logic           clk,
    input  logic           rst_n,
    slot_allocator_if.slave bus
);

    slot_mask_t busy_q, busy_d;
    slot_cnt_t  cnt_q, cnt_d;
    logic       err_q;

    logic [3:0] ctz_count;
    logic       full;
    logic       free_hit;
    logic       free_legal;
    logic       gnt_normal;
    logic       bypass;

    CountTrailingZero u_ctz (
        .val   (~busy_q),
        .count (ctz_count)
    );

    assign full       = (cnt_q == '0);
    assign free_hit   = busy_q[bus.free_idx];
    assign free_legal = bus.free_valid & free_hit & ~bus.flush;
    assign gnt_normal = rst_n & bus.alloc_req & ~full & ~bus.flush;

`ifdef SLOT_ALLOC_BYPASS_EN
    // Full and a slot is being released: give it to the requester without ever freeing it.
    assign bypass = rst_n & bus.alloc_req & full & free_legal;
`else
    assign bypass = 1'b0;
`endif

    assign bus.alloc_gnt       = gnt_normal | bypass;
    assign bus.alloc_idx       = bypass ? bus.free_idx : ctz_count[IdxW-1:0];
    assign bus.busy_mask       = busy_q;
    assign bus.free_count      = cnt_q;
    assign bus.full            = full;
    assign bus.err_double_free = err_q;

    always_comb begin
        busy_d = busy_q;
        cnt_d  = cnt_q;
        if (!bypass) begin
            if (gnt_normal) busy_d[ctz_count[IdxW-1:0]] = 1'b1;
            if (free_legal) busy_d[bus.free_idx] = 1'b0;
            case ({gnt_normal, free_legal})
                2'b10:   cnt_d = cnt_q - slot_cnt_t'(1);
                2'b01:   cnt_d = cnt_q + slot_cnt_t'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_q <= RESET_BUSY;
            cnt_q  <= popcount_free(RESET_BUSY);
            err_q  <= 1'b0;
        end else if (bus.flush) begin
            busy_q <= RESET_BUSY;
            cnt_q  <= popcount_free(RESET_BUSY);
            err_q  <= 1'b0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
            err_q  <= bus.free_valid & ~free_hit;
        end
    end

    // The scanner's "no free slot" result must agree with the counter.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (ctz_count[3] == full);
        end
    end

endmodule

// File: doc/slot_allocator.md
SLOT_ALLOCATOR -- requirements
Module: slot_allocator

Interface
REQ-001 SHALL have parameter RESET_BUSY, default 8'h00: slots marked busy at reset and after flush (reserved slots).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port alloc_req  input  1  requester wants one slot this cycle.
REQ-005 SHALL have port alloc_gnt  output  1  request granted this cycle; slot is busy from the next edge.
REQ-006 SHALL have port alloc_idx  output  3  granted slot index; valid only when alloc_gnt=1.
REQ-007 SHALL have port free_valid  input  1  release one slot this cycle.
REQ-008 SHALL have port free_idx  input  3  slot index to release.
REQ-009 SHALL have port flush  input  1  return every non-reserved slot to free.
REQ-010 SHALL have port busy_mask  output  8  registered busy bitmap; bit i=1 means slot i is in use.
REQ-011 SHALL have port free_count  output  4  registered number of free slots, 0..8.
REQ-012 SHALL have port full  output  1  free_count==0.
REQ-013 SHALL have port err_double_free  output  1  registered one-cycle pulse on an illegal free.

Function
REQ-014 SHALL select alloc_idx as the lowest-numbered free slot: trailing-zero count of ~busy_mask.
REQ-015 SHALL assert alloc_gnt combinationally as alloc_req & !full & !flush; zero-cycle grant latency.
REQ-016 SHALL, on a grant, set busy_mask[alloc_idx] at the next edge.
REQ-017 SHALL decrement free_count by 1 at that edge.
REQ-018 SHALL, on free_valid with busy_mask[free_idx]=1, clear that bit at the next edge.
REQ-019 SHALL increment free_count by 1 at that edge.
REQ-020 SHALL, on free_valid with busy_mask[free_idx]=0, leave state unchanged and pulse err_double_free on the next cycle.
REQ-021 SHALL, on a simultaneous legal grant and legal free (necessarily different slots), apply both and leave free_count unchanged.
REQ-022 SHALL, on flush, set busy_mask=RESET_BUSY and free_count=popcount(~RESET_BUSY) at the next edge.
REQ-023 SHALL ignore any free in the same cycle as flush, and SHALL NOT raise err_double_free for it.
REQ-024 SHALL keep free_count == popcount(~busy_mask) at every edge.
REQ-025 SHALL hold busy_mask and free_count when alloc_req=0 and free_valid=0 and flush=0.

Reset
REQ-026 SHALL, while rst_n=0 at a clock edge, load busy_mask=RESET_BUSY and free_count=popcount(~RESET_BUSY).
REQ-027 SHALL clear err_double_free on reset.
REQ-028 SHALL keep alloc_gnt=0 while rst_n=0, regardless of alloc_req.
REQ-029 SHALL abandon any in-flight grant or free whose edge coincides with reset.

Configuration
REQ-030 SHALL support macro SLOT_ALLOC_BYPASS_EN.
REQ-031 SHALL, with SLOT_ALLOC_BYPASS_EN defined, grant when full=1, free_valid=1, busy_mask[free_idx]=1 and alloc_req=1.
REQ-032 SHALL, in that bypass case, set alloc_idx=free_idx, keep the slot busy, and leave free_count at 0.
REQ-033 SHALL, without SLOT_ALLOC_BYPASS_EN, give alloc_gnt=0 whenever full=1; the free completes normally.

Structure
REQ-034 SHALL place the slot count (8), the slot index typedef (3 bits) and the mask typedef (8 bits) in the shared utilities package.
REQ-035 SHALL instantiate the existing CountTrailingZero utility (8-bit val, 4-bit count) on ~busy_mask to compute alloc_idx.
REQ-036 SHALL use count bit 3 (count=8) only as a cross-check of full; no other sub-modules.

Verification
REQ-037 SHALL cover: reset with RESET_BUSY=8'h01, then 8 consecutive alloc_req cycles -> alloc_idx 1,2,...,7, gnt on 7 cycles; 8th cycle gnt=0, full=1, free_count=0.
REQ-038 SHALL cover: busy_mask=8'hFF, free_idx=3 -> next cycle busy_mask=8'hF7, free_count=1; following alloc_req -> alloc_idx=3.
REQ-039 SHALL cover: busy_mask=8'h0F, alloc_req plus free_idx=1 same cycle -> alloc_idx=4, next busy_mask=8'h1D, free_count=4 unchanged.
REQ-040 SHALL cover: busy_mask=8'h00, free_idx=5 -> state unchanged, err_double_free=1 for exactly one cycle.
REQ-041 SHALL cover: busy_mask=8'hFF with flush=1, alloc_req=1, free_idx=2 -> alloc_gnt=0, next busy_mask=RESET_BUSY, err_double_free=0.
REQ-042 SHALL cover: full, alloc_req plus free_idx=6 -> with SLOT_ALLOC_BYPASS_EN, gnt=1, alloc_idx=6, busy_mask stays 8'hFF; without it, gnt=0, next busy_mask=8'hBF.
